// File: rtl/usb_packet_receiver.sv
// USB packet receiver: locks on SYNC, validates the PID, forwards the payload, checks
// CRC5/CRC16 and length, and reports one status strobe per packet at EOP.
module usb_packet_receiver #(
    parameter int MAX_BYTES = 67,
    parameter int CNT_W     = 7
) (
    input  logic             useClk,
    input  logic             reset,
    input  logic [7:0]       byteData,
    input  logic             byteValid,
    input  logic             eop,
    output logic [7:0]       dataOut,
    output logic             dataValid,
    output logic             pktDone,
    output logic             pktOk,
    output logic [3:0]       pktPid,
    output logic [CNT_W-1:0] byteCount,
    output logic             errPid,
    output logic             errCrc,
    output logic             errLen
);

    // Handshake: byteValid qualifies byteData for exactly one cycle with no backpressure;
    // dataValid qualifies dataOut and pktDone qualifies the status outputs the same way.
    typedef enum logic [2:0] {IDLE, PID, PAYLOAD, DISCARD, DONE} state_t;

    state_t           state;
    logic             eopQ;
    logic             eopRise;
    logic [3:0]       pid;
    logic [CNT_W-1:0] count;
    logic [4:0]       crc5;
    logic [15:0]      crc16;
    logic             stickyPid;
    logic             stickyLen;
    logic             lenBad;
    logic             crcBad;

    // Serial LSB-first update, register bit n = x^n coefficient.
    function automatic logic [4:0] crc5Byte(input logic [4:0] crcIn, input logic [7:0] d);
        logic [4:0] c;
        c = crcIn;
        for (int i = 0; i < 8; i++) begin
            if (d[i] ^ c[4]) c = {c[3:0], 1'b0} ^ 5'h05;
            else             c = {c[3:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [15:0] crc16Byte(input logic [15:0] crcIn, input logic [7:0] d);
        logic [15:0] c;
        c = crcIn;
        for (int i = 0; i < 8; i++) begin
            if (d[i] ^ c[15]) c = {c[14:0], 1'b0} ^ 16'h8005;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    assign eopRise = eop & ~eopQ;

    always_comb begin
        lenBad = 1'b0;
        crcBad = 1'b0;
        case (pid[1:0])
            2'b01:   lenBad = (count != CNT_W'(3));
            2'b11:   lenBad = (count < CNT_W'(3));
            default: lenBad = (count != CNT_W'(1));
        endcase
        // A bad or missing PID makes the class unknown, so the CRC says nothing useful.
        if (!stickyPid && count != '0) begin
            case (pid[1:0])
                2'b01:   crcBad = (crc5 != 5'b01100);
                2'b11:   crcBad = (crc16 != 16'h800D);
                default: crcBad = 1'b0;
            endcase
        end
    end

    always_ff @(posedge useClk) begin
        if (reset) begin
            state     <= IDLE;
            eopQ      <= 1'b1;
            pid       <= '0;
            count     <= '0;
            crc5      <= 5'h1F;
            crc16     <= 16'hFFFF;
            stickyPid <= 1'b0;
            stickyLen <= 1'b0;
            dataOut   <= '0;
            dataValid <= 1'b0;
            pktDone   <= 1'b0;
            pktOk     <= 1'b0;
            pktPid    <= '0;
            byteCount <= '0;
            errPid    <= 1'b0;
            errCrc    <= 1'b0;
            errLen    <= 1'b0;
        end else begin
            eopQ      <= eop;
            dataValid <= 1'b0;
            pktDone   <= 1'b0;
            case (state)
                IDLE: begin
                    if (byteValid && byteData == 8'h80) begin
                        state     <= PID;
                        count     <= '0;
                        crc5      <= 5'h1F;
                        crc16     <= 16'hFFFF;
                        stickyPid <= 1'b0;
                        stickyLen <= 1'b0;
                    end
                end
                PID: begin
                    if (byteValid) begin
                        count <= CNT_W'(1);
                        pid   <= byteData[3:0];
                        crc5  <= 5'h1F;
                        crc16 <= 16'hFFFF;
                        if (byteData[7:4] != ~byteData[3:0]) begin
                            stickyPid <= 1'b1;
                            state     <= eopRise ? DONE : DISCARD;
                        end else begin
                            state     <= eopRise ? DONE : PAYLOAD;
                        end
                    end else if (eopRise) begin
                        stickyLen <= 1'b1;
                        state     <= DONE;
                    end
                end
                PAYLOAD: begin
                    if (byteValid) begin
                        if (count == CNT_W'(MAX_BYTES)) begin
                            stickyLen <= 1'b1;
                            state     <= DISCARD;
                        end else begin
                            count     <= count + 1'b1;
                            dataOut   <= byteData;
                            dataValid <= 1'b1;
                            crc5      <= crc5Byte(crc5, byteData);
                            crc16     <= crc16Byte(crc16, byteData);
                        end
                    end
                    // A byte arriving with the EOP edge is taken above before closing.
                    if (eopRise) state <= DONE;
                end
                DISCARD: begin
                    if (eopRise) state <= DONE;
                end
                DONE: begin
                    pktDone   <= 1'b1;
                    pktPid    <= pid;
                    byteCount <= count;
                    errPid    <= stickyPid;
                    errCrc    <= crcBad;
                    errLen    <= stickyLen | (~stickyPid & lenBad);
                    pktOk     <= ~(stickyPid | crcBad | stickyLen | (~stickyPid & lenBad));
                    stickyPid <= 1'b0;
                    stickyLen <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_packet_receiver.sv
// Directed bench for usb_packet_receiver: hand-computed packets with inline checks per scenario.
module tb_usb_packet_receiver;

    logic       useClk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] byteData = '0;
    logic       byteValid = 1'b0;
    logic       eop = 1'b1;
    logic [7:0] dataOut;
    logic       dataValid;
    logic       pktDone;
    logic       pktOk;
    logic [3:0] pktPid;
    logic [6:0] byteCount;
    logic       errPid;
    logic       errCrc;
    logic       errLen;

    int checks = 0;
    int failures = 0;
    int doneCnt = 0;
    int overlapCnt = 0;
    int startDone = 0;
    int earlyDone = 0;
    bit waitOk;
    logic [3:0] capStat;  // {pktOk, errPid, errCrc, errLen}
    logic [3:0] capPid;
    logic [6:0] capCount;
    logic [7:0] txQ[$];
    logic [7:0] gotQ[$];
    logic [7:0] exp_q[$];

    usb_packet_receiver #(.MAX_BYTES(67), .CNT_W(7)) dut (
        .useClk(useClk), .reset(reset), .byteData(byteData), .byteValid(byteValid),
        .eop(eop), .dataOut(dataOut), .dataValid(dataValid), .pktDone(pktDone),
        .pktOk(pktOk), .pktPid(pktPid), .byteCount(byteCount), .errPid(errPid),
        .errCrc(errCrc), .errLen(errLen)
    );

    always #5 useClk = ~useClk;

    always @(negedge useClk) begin
        if (dataValid) gotQ.push_back(dataOut);
        if (pktDone) begin
            doneCnt  <= doneCnt + 1;
            capStat  <= {pktOk, errPid, errCrc, errLen};
            capPid   <= pktPid;
            capCount <= byteCount;
        end
        if (dataValid && pktDone) overlapCnt <= overlapCnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic runPacket(input bit sameEop);
        @(negedge useClk);
        #1;
        startDone = doneCnt;
        gotQ.delete();
        eop = 1'b0;
        for (int i = 0; i < txQ.size(); i++) begin
            @(negedge useClk);
            byteData  = txQ[i];
            byteValid = 1'b1;
            if (sameEop && i == txQ.size() - 1) eop = 1'b1;
        end
        @(negedge useClk);
        byteValid = 1'b0;
        byteData  = '0;
        #1;
        earlyDone = doneCnt;
        eop = 1'b1;
        waitOk = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge useClk);
            #1;
            if (doneCnt != startDone) begin
                waitOk = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge useClk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge useClk);
        reset = 1'b0;
        @(negedge useClk);
        #1;
        checks++; if ({dataValid, pktDone, pktOk, errPid, errCrc, errLen} !== 6'b0) begin
            failures++; $display("FAIL reset_flags got=%b want=000000", {dataValid, pktDone, pktOk, errPid, errCrc, errLen});
        end
        checks++; if (pktPid !== 4'h0 || byteCount !== 7'd0 || dataOut !== 8'h00) begin
            failures++; $display("FAIL reset_values pid=%h cnt=%0d data=%h want 0", pktPid, byteCount, dataOut);
        end
    endtask

    task automatic test_ack();
        txQ = '{8'h80, 8'hD2};
        runPacket(1'b0);
        checks++; if (waitOk !== 1'b1) begin failures++; $display("FAIL ack_done timeout got=0 want=1"); end
        checks++; if (capStat !== 4'b1000) begin failures++; $display("FAIL ack_status got=%b want=1000", capStat); end
        checks++; if (capPid !== 4'h2 || capCount !== 7'd1) begin
            failures++; $display("FAIL ack_pid_count got=%h/%0d want=2/1", capPid, capCount);
        end
        checks++; if (gotQ.size() != 0) begin failures++; $display("FAIL ack_nodata got=%0d want=0", gotQ.size()); end
    endtask

    task automatic test_setup(input bit sameEop);
        txQ = '{8'h80, 8'h2D, 8'h00, 8'h10};
        exp_q = '{8'h00, 8'h10};
        runPacket(sameEop);
        checks++; if (waitOk !== 1'b1) begin failures++; $display("FAIL setup_done same=%0d timeout", sameEop); end
        checks++; if (capStat !== 4'b1000) begin failures++; $display("FAIL setup_status same=%0d got=%b want=1000", sameEop, capStat); end
        checks++; if (capPid !== 4'hD || capCount !== 7'd3) begin
            failures++; $display("FAIL setup_pid_count same=%0d got=%h/%0d want=d/3", sameEop, capPid, capCount);
        end
        checks++; if (gotQ.size() != exp_q.size()) begin
            failures++; $display("FAIL setup_len same=%0d got=%0d want=%0d", sameEop, gotQ.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++; if (gotQ[i] !== exp_q[i]) begin
                    failures++; $display("FAIL setup_data[%0d] got=%h want=%h", i, gotQ[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_bad_crc();
        txQ = '{8'h80, 8'h2D, 8'h00, 8'h11};
        runPacket(1'b0);
        checks++; if (waitOk !== 1'b1) begin failures++; $display("FAIL badcrc_done timeout"); end
        checks++; if (capStat !== 4'b0010) begin failures++; $display("FAIL badcrc_status got=%b want=0010", capStat); end
        checks++; if (capCount !== 7'd3) begin failures++; $display("FAIL badcrc_count got=%0d want=3", capCount); end
    endtask

    task automatic test_zlp_data0();
        txQ = '{8'h80, 8'hC3, 8'h00, 8'h00};
        runPacket(1'b0);
        checks++; if (waitOk !== 1'b1) begin failures++; $display("FAIL zlp_done timeout"); end
        checks++; if (capStat !== 4'b1000) begin failures++; $display("FAIL zlp_status got=%b want=1000", capStat); end
        checks++; if (capPid !== 4'h3 || capCount !== 7'd3) begin
            failures++; $display("FAIL zlp_pid_count got=%h/%0d want=3/3", capPid, capCount);
        end
        checks++; if (gotQ.size() != 2) begin failures++; $display("FAIL zlp_len got=%0d want=2", gotQ.size()); end
    endtask

    task automatic test_bad_pid();
        txQ = '{8'h80, 8'hD3, 8'h55};
        runPacket(1'b0);
        checks++; if (waitOk !== 1'b1) begin failures++; $display("FAIL badpid_done timeout"); end
        checks++; if (capStat[3:2] !== 2'b01) begin failures++; $display("FAIL badpid_status got=%b want=01xx", capStat); end
        checks++; if (gotQ.size() != 0) begin failures++; $display("FAIL badpid_nodata got=%0d want=0", gotQ.size()); end
    endtask

    task automatic test_no_pid();
        txQ = '{8'h80};
        runPacket(1'b0);
        checks++; if (waitOk !== 1'b1) begin failures++; $display("FAIL nopid_done timeout"); end
        checks++; if (capStat[3] !== 1'b0 || capStat[0] !== 1'b1) begin
            failures++; $display("FAIL nopid_status got=%b want=0xx1", capStat);
        end
        checks++; if (capCount !== 7'd0) begin failures++; $display("FAIL nopid_count got=%0d want=0", capCount); end
    endtask

    task automatic test_overflow();
        txQ = '{8'h80, 8'hC3};
        exp_q = {};
        for (int i = 0; i < 70; i++) begin
            txQ.push_back(8'(i + 1));
            if (i < 66) exp_q.push_back(8'(i + 1));
        end
        runPacket(1'b0);
        checks++; if (earlyDone != startDone) begin failures++; $display("FAIL ovf_early_done got=%0d want=%0d", earlyDone, startDone); end
        checks++; if (waitOk !== 1'b1) begin failures++; $display("FAIL ovf_done timeout"); end
        checks++; if (capStat[3] !== 1'b0 || capStat[2] !== 1'b0 || capStat[0] !== 1'b1) begin
            failures++; $display("FAIL ovf_status got=%b want=00x1", capStat);
        end
        checks++; if (capCount !== 7'd67) begin failures++; $display("FAIL ovf_count got=%0d want=67", capCount); end
        checks++; if (gotQ.size() != exp_q.size()) begin
            failures++; $display("FAIL ovf_len got=%0d want=%0d", gotQ.size(), exp_q.size());
        end else begin
            checks++; if (gotQ[65] !== exp_q[65]) begin failures++; $display("FAIL ovf_last got=%h want=%h", gotQ[65], exp_q[65]); end
        end
    endtask

    task automatic test_reset_midpacket();
        @(negedge useClk);
        #1;
        startDone = doneCnt;
        eop = 1'b0;
        txQ = '{8'h80, 8'hC3, 8'h01};
        for (int i = 0; i < txQ.size(); i++) begin
            @(negedge useClk);
            byteData  = txQ[i];
            byteValid = 1'b1;
        end
        @(negedge useClk);
        byteValid = 1'b0;
        reset = 1'b1;
        @(negedge useClk);
        reset = 1'b0;
        #1;
        gotQ.delete();
        checks++; if (dataValid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b want=0", dataValid); end
        @(negedge useClk);
        eop = 1'b1;
        repeat (6) @(negedge useClk);
        #1;
        checks++; if (doneCnt != startDone) begin failures++; $display("FAIL rst_mid_nodone got=%0d want=%0d", doneCnt, startDone); end
        checks++; if (gotQ.size() != 0) begin failures++; $display("FAIL rst_mid_nodata got=%0d want=0", gotQ.size()); end
        test_ack();
    endtask

    initial begin
        test_reset();
        test_ack();
        test_setup(1'b0);
        test_bad_crc();
        test_zlp_data0();
        test_bad_pid();
        test_no_pid();
        test_overflow();
        test_setup(1'b1);
        test_reset_midpacket();
        checks++; if (overlapCnt != 0) begin failures++; $display("FAIL done_valid_overlap got=%0d want=0", overlapCnt); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
